// File: rtl/uart8.sv
// 8N1 UART transceiver: 16x-oversampled receiver with false-start and framing
// detection, plus an independent transmitter. Both paths share one clock.
`timescale 1ns/1ps
module uart8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RXC_W  = $clog2(RX_DIV + 1);
  localparam int TXC_W  = $clog2(TX_DIV + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Receive baud generator and input synchronizer
  logic [RXC_W-1:0] rx_div_q;
  logic [1:0]       rx_sync_q;
  logic             rx_tick;
  logic             rx_s;

  assign rx_tick = (rx_div_q == RXC_W'(RX_DIV - 1));
  assign rx_s    = rx_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_div_q  <= '0;
      rx_sync_q <= 2'b11;
    end else begin
      rx_div_q  <= rx_tick ? '0 : rx_div_q + RXC_W'(1);
      rx_sync_q <= {rx_sync_q[0], rxIn};
    end
  end

  // Receive FSM
  state_t     rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_out_q, rx_out_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_err_q, rx_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_out_q   <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_out_q   <= rx_out_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_out_d   = rx_out_q;
    rx_done_d  = 1'b0;
    rx_err_d   = rx_err_q;
    if (!rxEn) begin
      rx_state_d = ST_IDLE;
    end else if (rx_tick) begin
      unique case (rx_state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            rx_state_d = ST_START;
            rx_cnt_d   = '0;
          end
        end
        ST_START: begin
          // Detection tick plus seven more low ticks lands on mid start bit
          if (rx_s) begin
            rx_err_d   = 1'b1;
            rx_state_d = ST_IDLE;
          end else if (rx_cnt_q == 4'd6) begin
            rx_err_d   = 1'b0;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = ST_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d   = '0;
            rx_state_d = ST_IDLE;
            if (rx_s) begin
              rx_out_d  = rx_shift_q;
              rx_done_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  assign rxBusy = (rx_state_q != ST_IDLE);
  assign rxDone = rx_done_q;
  assign rxErr  = rx_err_q;
  assign rxOut  = rx_out_q;

  // Transmit FSM; its baud counter is re-phased on every accepted start
  state_t           tx_state_q, tx_state_d;
  logic [TXC_W-1:0] tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_tick;

  assign tx_tick = (tx_div_q == TXC_W'(TX_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_tick ? '0 : tx_div_q + TXC_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    if (!txEn) begin
      tx_state_d = ST_IDLE;
    end else begin
      unique case (tx_state_q)
        ST_IDLE: begin
          if (txStart) begin
            tx_shift_d = txIn;
            tx_bit_d   = '0;
            tx_div_d   = '0;
            tx_state_d = ST_START;
          end
        end
        ST_START: if (tx_tick) tx_state_d = ST_DATA;
        ST_DATA: begin
          if (tx_tick) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            else                  tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
        ST_STOP: begin
          if (tx_tick) begin
            tx_state_d = ST_IDLE;
            tx_done_d  = 1'b1;
          end
        end
        default: tx_state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    txOut = 1'b1;
    if (tx_state_q == ST_START)     txOut = 1'b0;
    else if (tx_state_q == ST_DATA) txOut = tx_shift_q[0];
  end

  assign txBusy = (tx_state_q != ST_IDLE);
  assign txDone = tx_done_q;

endmodule

// File: tb/tb_uart8.sv
// Bench for uart8. The DUT runs at 1.2288 MHz / 9600 baud so a bit is exactly
// 128 clocks and a receive tick is 8 clocks, keeping frames short.
`timescale 1ns/1ps
module tb_uart8;

  localparam int BIT_CLK  = 128;
  localparam int FAST_BIT = 132;   // ~3% longer bit period
  localparam int GLITCH   = 52;    // ~6.5 receive ticks

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxEn, txEn, txStart;
  logic [7:0] txIn;
  logic       rxBusy, rxDone, rxErr, txBusy, txDone, txOut;
  logic [7:0] rxOut;
  logic       rx_drv, loop_en, rx_line;

  int checks = 0;
  int failures = 0;
  int tx_done_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign rx_line = loop_en ? txOut : rx_drv;

  uart8 #(.CLOCK_RATE(1228800), .BAUD_RATE(9600)) dut (
    .clk(clk), .rst_n(rst_n),
    .rxEn(rxEn), .rxIn(rx_line), .rxBusy(rxBusy), .rxDone(rxDone),
    .rxErr(rxErr), .rxOut(rxOut),
    .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
  );

  always #407 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Drive nbits of an 8N1 frame; a low stop bit is shortened so the line is
  // back high before a trailing low could be validated as a new start bit.
  task automatic send_rx(input logic [7:0] d, input int bclk, input logic stopv,
                         input int nbits, input bit chk_busy);
    logic [9:0] fr;
    int len;
    fr = {stopv, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_drv = fr[i];
      len = (i == 9 && !stopv) ? (bclk * 3) / 4 : bclk;
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        if (chk_busy && i == 0 && j == 11) check("rx_busy_at_start", {31'b0, rxBusy}, 32'd1);
      end
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (txBusy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_timeout", {31'b0, txBusy}, 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rxBusy"}, {31'b0, rxBusy}, 32'd0);
    check({pfx, "_rxDone"}, {31'b0, rxDone}, 32'd0);
    check({pfx, "_rxErr"},  {31'b0, rxErr},  32'd0);
    check({pfx, "_rxOut"},  {24'b0, rxOut},  32'd0);
    check({pfx, "_txBusy"}, {31'b0, txBusy}, 32'd0);
    check({pfx, "_txDone"}, {31'b0, txDone}, 32'd0);
    check({pfx, "_txOut"},  {31'b0, txOut},  32'd1);
  endtask

  // Receive scoreboard
  always @(negedge clk) begin
    if (rst_n && rxDone) begin
      if (rx_q.size() == 0) begin
        check("rx_unexpected_done", {24'b0, rxOut}, 32'hFFFF_FFFF);
      end else begin
        check("rx_byte", {24'b0, rxOut}, {24'b0, rx_q.pop_front()});
        check("rx_err_at_done", {31'b0, rxErr}, 32'd0);
      end
    end
  end

  always @(negedge clk) if (txDone) tx_done_cnt++;

  // Transmit monitor: frames with a queued expectation are sampled early,
  // mid and late in every bit, and the busy/done timing is checked exactly.
  initial begin
    logic prev;
    logic [9:0] fe, o_early, o_mid, o_late;
    prev = 1'b0;
    o_early = '0; o_mid = '0; o_late = '0;
    forever begin
      @(negedge clk);
      if (txBusy && !prev && tx_q.size() > 0) begin
        fe = {1'b1, tx_q.pop_front(), 1'b0};
        for (int n = 1; n <= 10 * BIT_CLK; n++) begin
          @(negedge clk);
          if (n % BIT_CLK == 1)           o_early[n / BIT_CLK] = txOut;
          if (n % BIT_CLK == BIT_CLK / 2) o_mid[n / BIT_CLK]   = txOut;
          if (n % BIT_CLK == BIT_CLK - 1) o_late[n / BIT_CLK]  = txOut;
          if (n == 10 * BIT_CLK - 1) check("tx_busy_last", {31'b0, txBusy}, 32'd1);
          if (n == 10 * BIT_CLK) begin
            check("tx_busy_end", {31'b0, txBusy}, 32'd0);
            check("tx_done_end", {31'b0, txDone}, 32'd1);
          end
        end
        check("tx_bits_early", {22'b0, o_early}, {22'b0, fe});
        check("tx_bits_mid",   {22'b0, o_mid},   {22'b0, fe});
        check("tx_bits_late",  {22'b0, o_late},  {22'b0, fe});
      end
      prev = txBusy;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lb [3];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;
    rst_n = 1'b0; rxEn = 1'b1; txEn = 1'b1; txStart = 1'b0; txIn = 8'h00;
    rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Valid frame with a 3% slow transmitter
    rx_q.push_back(8'h35);
    send_rx(8'h35, FAST_BIT, 1'b1, 10, 1'b1);
    repeat (256) @(negedge clk);
    check("valid_busy_after", {31'b0, rxBusy}, 32'd0);
    check("valid_err", {31'b0, rxErr}, 32'd0);

    // Glitch shorter than half a bit
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy", {31'b0, rxBusy}, 32'd1);
    repeat (GLITCH - 20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (256) @(negedge clk);
    check("glitch_err", {31'b0, rxErr}, 32'd1);
    check("glitch_busy_after", {31'b0, rxBusy}, 32'd0);
    rx_q.push_back(8'hC3);
    send_rx(8'hC3, BIT_CLK, 1'b1, 10, 1'b0);
    repeat (256) @(negedge clk);
    check("err_cleared", {31'b0, rxErr}, 32'd0);

    // Framing error
    send_rx(8'hA5, BIT_CLK, 1'b0, 10, 1'b0);
    repeat (256) @(negedge clk);
    check("frame_err", {31'b0, rxErr}, 32'd1);
    check("frame_busy", {31'b0, rxBusy}, 32'd0);
    check("frame_rxout_held", {24'b0, rxOut}, 32'hC3);

    // Transmit 0x35 with an ignored start request mid-frame
    @(negedge clk);
    tx_q.push_back(8'h35);
    txIn = 8'h35; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0; txIn = 8'h00;
    repeat (400) @(negedge clk);
    txIn = 8'hFF; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    wait_tx_idle();
    repeat (10) @(negedge clk);
    check("tx_stays_idle", {31'b0, txBusy}, 32'd0);

    // Reset while both paths are mid-frame
    txIn = 8'h96; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    send_rx(8'h0F, BIT_CLK, 1'b1, 5, 1'b0);
    check("pre_rst_rx_busy", {31'b0, rxBusy}, 32'd1);
    check("pre_rst_tx_busy", {31'b0, txBusy}, 32'd1);
    rst_n = 1'b0;
    #50;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rx_q.push_back(8'h0F);
    send_rx(8'h0F, BIT_CLK, 1'b1, 10, 1'b0);
    repeat (256) @(negedge clk);

    // Loopback, back-to-back frames
    loop_en = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_tx_idle();
      rx_q.push_back(lb[k]);
      tx_q.push_back(lb[k]);
      txIn = lb[k]; txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
    end
    wait_tx_idle();
    repeat (300) @(negedge clk);
    check("loop_err", {31'b0, rxErr}, 32'd0);
    check("rx_queue_drained", rx_q.size(), 32'd0);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("tx_done_count", tx_done_cnt, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
